// File: rtl/lif_tick_scheduler.sv
// lif_tick_scheduler: programmable timestep tick generator that launches one
// neuron-index sweep per tick over a valid/ready handshake and flags overruns.
module lif_tick_scheduler #(
    parameter int CNT_W          = 16,
    parameter int NEURONS        = 254,
    parameter int IDX_W          = 8,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int TCNT_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic              period_we_i,
    output logic              tick_o,
    output logic [TCNT_W-1:0] tick_cnt_o,
    output logic [IDX_W-1:0]  nrn_idx_o,
    output logic              nrn_valid_o,
    input  logic              nrn_ready_i,
    output logic              nrn_last_o,
    output logic              sweep_busy_o,
    output logic              overrun_o,
    input  logic              overrun_clr_i
);
    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    localparam logic [CNT_W-1:0] P_DEF  = CNT_W'(DEFAULT_PERIOD);
    localparam logic [IDX_W-1:0] P_LAST = IDX_W'(NEURONS - 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_clk_cnt, r_period_act, r_period_shd, w_cnt_last;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [TCNT_W-1:0]  r_tick_cnt;
    logic               r_overrun, w_tick, w_hs, w_done, w_ovr_set;

    // Period 0 behaves as period 1, so the wrap point clamps at 0.
    assign w_cnt_last = (r_period_act == '0) ? '0 : r_period_act - 1'b1;
    assign w_tick     = en_i & ~rst_i & (r_clk_cnt == w_cnt_last);
    assign w_hs       = (r_state == S_SWEEP) & nrn_ready_i;
    assign w_done     = w_hs & (r_idx == P_LAST);
    assign w_ovr_set  = w_tick & (r_state == S_SWEEP) & ~w_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clk_cnt    <= '0;
            r_period_act <= P_DEF;
            r_period_shd <= P_DEF;
            r_tick_cnt   <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_tick) begin
                r_clk_cnt    <= '0;
                r_period_act <= period_we_i ? period_i : r_period_shd;
                r_tick_cnt   <= r_tick_cnt + 1'b1;
            end else if (en_i) begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
            if (period_we_i) r_period_shd <= period_i;
            r_overrun <= w_ovr_set | (r_overrun & ~overrun_clr_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // A tick landing on the final handshake chains straight into a new sweep.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (r_state == S_IDLE) begin
            w_state_nxt = w_tick ? S_SWEEP : S_IDLE;
            w_idx_nxt   = '0;
        end else if (w_done) begin
            w_state_nxt = w_tick ? S_SWEEP : S_IDLE;
            w_idx_nxt   = '0;
        end else if (w_hs) begin
            w_idx_nxt = r_idx + 1'b1;
        end
    end

    assign tick_o       = w_tick;
    assign tick_cnt_o   = r_tick_cnt;
    assign nrn_idx_o    = r_idx;
    assign nrn_valid_o  = r_state == S_SWEEP;
    assign sweep_busy_o = r_state == S_SWEEP;
    assign nrn_last_o   = (r_state == S_SWEEP) & (r_idx == P_LAST);
    assign overrun_o    = r_overrun;
endmodule

// File: tb/tb_lif_tick_scheduler.sv
// tb_lif_tick_scheduler: directed plus randomized stimulus against a cycle-level
// behavioural model of tick timing, sweeps and overrun.
module tb_lif_tick_scheduler;
    localparam int CW = 8, N = 8, IW = 3, DP = 10, TW = 4;

    logic          clk = 1'b0, rst, en, we, ready, clr;
    logic [CW-1:0] per;
    logic          tick_o, nrn_valid_o, nrn_last_o, sweep_busy_o, overrun_o;
    logic [TW-1:0] tick_cnt_o;
    logic [IW-1:0] nrn_idx_o;

    int checks = 0, errors = 0;
    int m_cnt, m_per, m_shd, m_tcnt, m_pos, m_ovr;
    int cyc;
    int tq[$];

    lif_tick_scheduler #(.CNT_W(CW), .NEURONS(N), .IDX_W(IW), .DEFAULT_PERIOD(DP), .TCNT_W(TW)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .period_i(per), .period_we_i(we),
        .tick_o(tick_o), .tick_cnt_o(tick_cnt_o), .nrn_idx_o(nrn_idx_o),
        .nrn_valid_o(nrn_valid_o), .nrn_ready_i(ready), .nrn_last_o(nrn_last_o),
        .sweep_busy_o(sweep_busy_o), .overrun_o(overrun_o), .overrun_clr_i(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_per = DP; m_shd = DP; m_tcnt = 0; m_pos = -1; m_ovr = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tick"}, int'(tick_o), 0);
        chk({tag, "_tcnt"}, int'(tick_cnt_o), 0);
        chk({tag, "_idx"}, int'(nrn_idx_o), 0);
        chk({tag, "_valid"}, int'(nrn_valid_o), 0);
        chk({tag, "_last"}, int'(nrn_last_o), 0);
        chk({tag, "_busy"}, int'(sweep_busy_o), 0);
        chk({tag, "_ovr"}, int'(overrun_o), 0);
    endtask

    // One clock: drive, compare against the model, then advance the model.
    task automatic step(input logic e, input logic w, input int p, input logic r, input logic c);
        int eff;
        bit t, v, hs, done;
        @(negedge clk);
        en = e; we = w; per = p[CW-1:0]; ready = r; clr = c;
        #1;
        cyc++;
        eff = (m_per == 0) ? 1 : m_per;
        t = e && (m_cnt == eff - 1);
        v = m_pos >= 0;
        chk("tick", int'(tick_o), int'(t));
        chk("tick_cnt", int'(tick_cnt_o), m_tcnt % (1 << TW));
        chk("valid", int'(nrn_valid_o), int'(v));
        chk("busy", int'(sweep_busy_o), int'(v));
        chk("idx", int'(nrn_idx_o), v ? m_pos : 0);
        chk("last", int'(nrn_last_o), int'(v && m_pos == N - 1));
        chk("overrun", int'(overrun_o), m_ovr);
        if (tick_o) tq.push_back(cyc);
        hs = v && r;
        done = hs && m_pos == N - 1;
        if (t && v && !done) m_ovr = 1;
        else if (c) m_ovr = 0;
        if (t) begin
            m_tcnt++;
            m_cnt = 0;
            m_per = w ? p : m_shd;
        end else if (e) m_cnt++;
        if (w) m_shd = p;
        if (!v) m_pos = t ? 0 : -1;
        else if (done) m_pos = t ? 0 : -1;
        else if (hs) m_pos++;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; per = '0; ready = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        tq.delete();
        // default period: ticks at enabled cycles 10, 20, 30
        repeat (35) step(1, 0, 0, 1, 0);
        chk("tick_at_10", tq.size() > 0 ? tq[0] : -1, 10);
        chk("tick_at_20", tq.size() > 1 ? tq[1] : -1, 20);
        chk("tick_at_30", tq.size() > 2 ? tq[2] : -1, 30);
        chk("tick_count_35", tq.size(), 3);
        // shadow write mid-period takes effect only after the next tick
        tq.delete();
        step(1, 1, 5, 1, 0);
        repeat (20) step(1, 0, 0, 1, 0);
        chk("tick_after_we", tq.size() > 0 ? tq[0] : -1, 40);
        chk("tick_p5_a", tq.size() > 1 ? tq[1] : -1, 45);
        chk("tick_p5_b", tq.size() > 2 ? tq[2] : -1, 50);
        chk("overrun_p5", int'(overrun_o), 1);
        // clear, shorter period, ready toggling
        step(1, 1, 4, 1, 1);
        for (int i = 0; i < 40; i++) step(1, 0, 0, logic'(i % 2), 0);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        // async reset while the sweep sits at idx 3
        for (int i = 0; i < 60 && m_pos != 3; i++) step(1, 0, 0, m_pos < 0 || m_pos > 3 ? 1'b1 : 1'b1, 0);
        chk("reached_idx3", m_pos, 3);
        @(negedge clk);
        en = 1'b0; we = 1'b0; clr = 1'b0; ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        tq.delete();
        repeat (25) step(1, 0, 0, 1, 0);
        chk("rst_first_tick", tq.size() > 0 ? tq[0] : -1, DP);
        chk("rst_second_tick", tq.size() > 1 ? tq[1] : -1, 2 * DP);
        // randomized operation incl. period 0, en gaps and tick_cnt wrap
        for (int i = 0; i < 800; i++)
            step(($urandom % 8) != 0, ($urandom % 16) == 0, int'($urandom % 13),
                 ($urandom % 3) != 0, ($urandom % 10) == 0);
        chk("wrapped", int'(m_tcnt >= (1 << TW)), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
